// File: rtl/mips_instr_encoder.sv
// Symbolic-request to MIPS word encoder that streams encoded instructions into
// consecutive instruction-memory words, starting at BASE, until stopped or full.
module mips_instr_encoder #(
    parameter int ADDR_W = 6,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [5:0]        req_funct,
    input  logic [15:0]       req_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LAST_A  = '1;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(2**ADDR_W);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [5:0]        opc;
    logic [31:0]       word;
    logic              accept;

    always_comb begin
        opc = 6'h00;
        case (req_op)
            3'd0: opc = 6'h00;
            3'd1: opc = 6'h23;
            3'd2: opc = 6'h2B;
            3'd3: opc = 6'h04;
            3'd4: opc = 6'h05;
            3'd5: opc = 6'h08;
            3'd6: opc = 6'h0D;
            3'd7: opc = 6'h0C;
            default: opc = 6'h00;
        endcase
        // I-type words drop rd/shamt/funct; the immediate goes in untouched
        if (req_op == 3'd0)
            word = {opc, req_rs, req_rt, req_rd, req_shamt, req_funct};
        else
            word = {opc, req_rs, req_rt, req_imm};
    end

    assign req_ready = (state == S_LOAD) & ~start & ~stop;
    assign accept    = req_valid & req_ready;
    assign full      = (state == S_FULL);
    assign busy      = (state == S_LOAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            addr      <= BASE_A;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                state <= S_LOAD;
                addr  <= BASE_A;
                count <= '0;
            end else if (stop) begin
                state <= S_IDLE;
            end else if (accept) begin
                mem_we    <= 1'b1;
                mem_addr  <= addr;
                mem_wdata <= word;
                if (count != DEPTH_C)
                    count <= count + 1'b1;
                // the top word is written normally; the address never wraps
                if (addr == LAST_A)
                    state <= S_FULL;
                else
                    addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomized + directed bench: stimulus pushes expected writes into a queue,
// an independent negedge monitor pops and compares every mem_we pulse.
module tb_mips_instr_encoder;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, stop, req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [4:0]        req_rs, req_rt, req_rd, req_shamt;
    logic [5:0]        req_funct;
    logic [15:0]       req_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full, busy;

    mips_instr_encoder #(.ADDR_W(ADDR_W), .BASE(0)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_shamt(req_shamt), .req_funct(req_funct), .req_imm(req_imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // reference model: 0 idle, 1 loading, 2 memory full
    int   mstate = 0;
    int   maddr  = 0;
    int   mcnt   = 0;
    bit   m_we   = 0;
    bit   lit_en = 0;
    logic [31:0] lit_word;

    int unsigned OPC [8] = '{32'h00, 32'h23, 32'h2B, 32'h04, 32'h05, 32'h08, 32'h0D, 32'h0C};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_word(input int unsigned op, rs, rt, rd, sh, fn, imm);
        int unsigned w;
        w = OPC[op] * (2**26) + rs * (2**21) + rt * (2**16);
        if (op == 0) w = w + rd * (2**11) + sh * 64 + fn;
        else         w = w + imm;
        return 32'(w);
    endfunction

    task automatic set_req(input int op, rs, rt, rd, sh, fn, imm);
        req_op = 3'(op); req_rs = 5'(rs); req_rt = 5'(rt); req_rd = 5'(rd);
        req_shamt = 5'(sh); req_funct = 6'(fn); req_imm = 16'(imm);
    endtask

    task automatic rand_req();
        set_req(int'($urandom_range(7)), int'($urandom_range(31)), int'($urandom_range(31)),
                int'($urandom_range(31)), int'($urandom_range(31)), int'($urandom_range(63)),
                int'($urandom_range(65535)));
    endtask

    // one clock: drive at posedge+1, check at negedge, advance model at posedge
    task automatic step(input bit v, input bit st, input bit sp);
        exp_t e;
        req_valid = v; start = st; stop = sp;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'((mstate == 1) && !st && !sp));
        chk("busy", 32'(busy), 32'(mstate == 1));
        chk("full", 32'(full), 32'(mstate == 2));
        chk("count", 32'(count), 32'(mcnt));
        chk("mem_we", 32'(mem_we), 32'(m_we));
        @(posedge clk);
        m_we = 0;
        if (st) begin
            mstate = 1; maddr = 0; mcnt = 0;
        end else if (sp) begin
            mstate = 0;
        end else if (v && mstate == 1) begin
            e.addr = maddr;
            e.data = lit_en ? lit_word
                   : ref_word(req_op, req_rs, req_rt, req_rd, req_shamt, req_funct, req_imm);
            sbq.push_back(e);
            m_we = 1;
            if (mcnt < DEPTH) mcnt++;
            if (maddr == DEPTH-1) mstate = 2;
            else maddr++;
        end
        lit_en = 0;
        #1;
    endtask

    task automatic lit_req(input int op, rs, rt, rd, sh, fn, imm, input logic [31:0] w);
        set_req(op, rs, rt, rd, sh, fn, imm);
        lit_en = 1; lit_word = w;
        step(1, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && mem_we === 1'b1) begin
            if (sbq.size() == 0) chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            else begin
                e = sbq.pop_front();
                chk("wr_addr", 32'(mem_addr), e.addr);
                chk("wr_data", mem_wdata, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1; start = 0; stop = 0; req_valid = 0;
        set_req(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_flags", {29'd0, full, busy, req_ready}, 0);
        reset = 0;

        // basic R, LW/SW, branch and immediate encodings
        step(0, 1, 0);
        lit_req(0, 1, 2, 3, 0, 'h20, 0, 32'h00221820);
        step(0, 0, 0);
        chk("count_after_R", 32'(count), 1);
        step(0, 1, 0);
        lit_req(1, 29, 8, 0, 0, 0, 'h0004, 32'h8FA80004);
        lit_req(2, 29, 8, 0, 0, 0, 'h0004, 32'hAFA80004);
        lit_req(3, 4, 5, 7, 3, 9, 'hFFFF, 32'h1085FFFF);
        lit_req(4, 4, 5, 0, 0, 0, 'hFFFF, 32'h1485FFFF);
        lit_req(5, 0, 9, 31, 31, 63, 'h00FF, 32'h200900FF);
        lit_req(6, 0, 9, 0, 0, 0, 'h00FF, 32'h340900FF);
        lit_req(7, 0, 9, 0, 0, 0, 'h00FF, 32'h300900FF);
        step(0, 0, 0);

        // fill all 64 words with random valid gaps
        step(0, 1, 0);
        for (int i = 0; i < 400 && mstate == 1; i++) begin
            rand_req();
            step($urandom_range(9) < 8, 0, 0);
        end
        chk("reached_full", 32'(mstate), 2);
        rand_req();
        req_valid = 1;
        @(negedge clk);
        chk("full_flag", 32'(full), 1);
        chk("full_count", 32'(count), DEPTH);
        chk("full_ready", 32'(req_ready), 0);
        @(posedge clk); #1;
        m_we = 0;
        for (int i = 0; i < 3; i++) begin rand_req(); step(1, 0, 0); end
        step(0, 0, 1);
        step(0, 0, 0);

        // start while valid held, then stop while valid held
        step(0, 1, 0);
        for (int i = 0; i < 5; i++) begin rand_req(); step(1, 0, 0); end
        rand_req();
        step(1, 1, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("restart_count", 32'(count), 1);
        rand_req();
        step(1, 0, 1);
        step(0, 0, 0);
        chk("stop_busy", 32'(busy), 0);

        // random traffic with occasional start/stop pulses
        for (int i = 0; i < 400; i++) begin
            rand_req();
            step($urandom_range(3) != 0, $urandom_range(40) == 0, $urandom_range(40) == 0);
        end
        step(0, 0, 0);
        step(0, 0, 0);

        // asynchronous reset right after an accept drops the in-flight write
        step(0, 1, 0);
        rand_req();
        step(1, 0, 0);
        reset = 1;
        #1;
        chk("arst_mem_we", 32'(mem_we), 0);
        chk("arst_mem_addr", 32'(mem_addr), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_full", 32'(full), 0);
        mstate = 0; maddr = 0; mcnt = 0; m_we = 0;
        sbq.delete();
        @(posedge clk); #1;
        reset = 0;
        step(0, 0, 0);
        step(0, 0, 0);

        chk("sb_empty", 32'(sbq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
